load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Multi-cycle load/store unit between the execute stage and writeback.
- Takes the ALU-computed address, store data, MemType and MemSign, and performs the access over a request/grant/rvalid data-memory bus.
- Handles byte-lane enables, store-data replication and load sign/zero extension.
- Stalls the core until the access completes and flags misaligned accesses instead of issuing them.

Parameters:
- DATA_WIDTH, 32, data and address width; byte-lane logic assumes 32.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_i  input  1  memory instruction valid this cycle
- MemWrite_i  input  1  1 = store, 0 = load
- MemType_i  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- MemSign_i  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- ALUResultM_i  input  DATA_WIDTH  byte address
- WriteDataM_i  input  DATA_WIDTH  store data, LSBs significant
- stall_o  output  1  hold upstream stages
- done_o  output  1  one-cycle pulse when the access completes
- misalign_o  output  1  one-cycle pulse for a rejected misaligned access
- RD_o  output  DATA_WIDTH  extended load result
- mem_req_o  output  1  bus request
- mem_we_o  output  1  bus write enable
- mem_addr_o  output  DATA_WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_be_o  output  4  byte enables
- mem_wdata_o  output  DATA_WIDTH  lane-replicated store data
- mem_gnt_i  input  1  bus accepted the request
- mem_rvalid_i  input  1  read data valid
- mem_rdata_i  input  DATA_WIDTH  read data

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE.
  - mem_req_o, mem_we_o, stall_o, done_o and misalign_o go to 0 immediately.
  - mem_addr_o, mem_be_o, mem_wdata_o and RD_o reset to 0.
  - An access in flight is abandoned and never completed.
- States are IDLE, REQ, WAIT and DONE.
- Misalignment:
  - A half access is misaligned if addr[0]=1.
  - A word or reserved access is misaligned if addr[1:0]!=0.
  - A byte access is never misaligned.
- IDLE:
  - req_i=1 and aligned: latch address, type, sign, we, be and wdata into registers; go to REQ.
  - req_i=1 and misaligned: misalign_o=1 next cycle for one cycle; no bus activity; stay IDLE.
  - req_i=0: stay IDLE.
- REQ:
  - mem_req_o=1 with all bus outputs stable until mem_gnt_i=1.
  - Store granted: go to DONE.
  - Load granted: go to WAIT.
- WAIT:
  - On mem_rvalid_i=1, extract and extend the selected lanes into RD_o; go to DONE.
  - mem_rvalid_i is ignored in IDLE, REQ and DONE. The bus returns data no earlier than the cycle after grant.
- DONE: done_o=1 for exactly one cycle; go to IDLE. A new req_i is accepted only from IDLE.
- stall_o is combinational:
  - 1 when state is REQ or WAIT.
  - 1 when state is IDLE with req_i=1 and the access aligned.
  - 0 in DONE, so the core advances in the done cycle.
  - 0 for misaligned requests.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word/reserved: 4'b1111
- Store data: byte replicated ×4, half replicated ×2, word passed through.
- Load extraction:
  - byte = rdata[8*addr[1:0]+:8]
  - half = rdata[16*addr[1]+:16]
  - Extension per the latched MemSign.
- RD_o holds the last load result until the next load completes. Stores never change RD_o.
- The latency floor is 2 cycles (store) and 3 cycles (load) from acceptance to done_o when grant is immediate.

Test Plan:
- Word load: addr 0x100, gnt in REQ, rvalid=1 one cycle later with rdata 0xDEADBEEF → RD_o=0xDEADBEEF; done_o pulses once; stall_o high for 3 cycles.
- Signed byte load: addr 0x103, rdata 0x80123456, MemSign=1 → RD_o=0xFFFFFF80. Same access with MemSign=0 → RD_o=0x00000080.
- Half store: addr 0x202, data 0x0000ABCD → mem_be_o=4'b1100, mem_wdata_o=0xABCDABCD, mem_addr_o=0x200; gnt held low 3 cycles → outputs stable and mem_req_o high throughout.
- Misaligned word load at 0x101 → misalign_o pulse, mem_req_o never asserted, stall_o=0, RD_o unchanged.
- Reset asserted in WAIT → mem_req_o/stall_o low immediately; a late rvalid after reset is ignored and RD_o=0.
- Back-to-back: store then load with req_i held → second access starts only from IDLE after DONE. Check that the done_o pulses are separated by at least one IDLE cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// Purpose: multi-cycle load/store unit between execute and writeback over a req/gnt/rvalid data bus.
// Latency: store 2 cycles, load 3 cycles from acceptance to done_o with immediate grant and data.
// Backpressure: stall_o holds the core while the access is in flight; the bus request waits on mem_gnt_i.
//
// Ports:
//   core side : req_i, MemWrite_i, MemType_i, MemSign_i, ALUResultM_i, WriteDataM_i
//               -> stall_o, done_o, misalign_o, RD_o
//   bus side  : mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
//               <- mem_gnt_i, mem_rvalid_i, mem_rdata_i
//   clk rising edge, rst asynchronous active-low.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  MemWrite_i,
    input  logic [1:0]            MemType_i,
    input  logic                  MemSign_i,
    input  logic [DATA_WIDTH-1:0] ALUResultM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] RD_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              type_q, type_d;
    logic                    sign_q, sign_d;
    logic                    we_q, we_d;
    logic [3:0]              be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rd_q, rd_d;
    logic                    req_q, req_d;
    logic                    done_q, done_d;
    logic                    misalign_q, misalign_d;

    logic                    misaligned;
    logic                    accept;
    logic [3:0]              be_in;
    logic [DATA_WIDTH-1:0]   wdata_in;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [DATA_WIDTH-1:0]   load_val;

    // Decode of the incoming request: alignment, lane enables, replicated store data.
    always_comb begin
        misaligned = 1'b0;
        be_in      = 4'b1111;
        wdata_in   = WriteDataM_i;
        case (MemType_i)
            2'b00: begin
                be_in    = 4'b0001 << ALUResultM_i[1:0];
                wdata_in = {4{WriteDataM_i[7:0]}};
            end
            2'b01: begin
                misaligned = ALUResultM_i[0];
                be_in      = 4'b0011 << {ALUResultM_i[1], 1'b0};
                wdata_in   = {2{WriteDataM_i[15:0]}};
            end
            default: begin
                // Reserved encoding behaves as a word access.
                misaligned = |ALUResultM_i[1:0];
            end
        endcase
    end

    assign accept = (state_q == S_IDLE) && req_i && !misaligned;

    // Lane extraction uses the latched byte offset, not the word-aligned bus address.
    always_comb begin
        byte_sel = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        half_sel = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (type_q)
            2'b00:   load_val = {{24{sign_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{sign_q & half_sel[15]}}, half_sel};
            default: load_val = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        type_d     = type_q;
        sign_d     = sign_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        req_d      = req_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i && misaligned) begin
                    misalign_d = 1'b1;
                end else if (accept) begin
                    addr_d  = ALUResultM_i;
                    type_d  = MemType_i;
                    sign_d  = MemSign_i;
                    we_d    = MemWrite_i;
                    be_d    = be_in;
                    wdata_d = wdata_in;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    rd_d    = load_val;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            type_q     <= 2'b00;
            sign_q     <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            rd_q       <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            type_q     <= type_d;
            sign_q     <= sign_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            req_q      <= req_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
        end
    end

    assign stall_o     = (state_q == S_REQ) || (state_q == S_WAIT) || accept;
    assign done_o      = done_q;
    assign misalign_o  = misalign_q;
    assign RD_o        = rd_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule
